// File: rtl/weight_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : weight_fetch_seq
// Purpose  : Upstream sequencer for the weight LUT. Accepts a burst command
//            {table, base offset, length}, issues one serial LUT read per
//            byte, packs the returned bytes into PACK-byte words and queues
//            them in a small FIFO that drains over a valid/ready stream.
// Ports    : clk, rst (sync, active-low)
//            cmd_valid/cmd_ready/cmd_table/cmd_base/cmd_len : burst command
//            lut_start/lut_addr/lut_data/lut_done           : LUT read port
//            out_valid/out_ready/out_data/out_last          : word stream
//            busy : FSM active or FIFO holding words
//            err  : sticky LUT timeout flag
// Options  : WFS_TIMEOUT_EN - enables an 8-bit WAIT watchdog that aborts a
//            burst after 255 cycles without lut_done and sets err.
//            Undefined: WAIT is unbounded and err is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module weight_fetch_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [15:0]                  cmd_table,
  input  logic [15:0]                  cmd_base,
  input  logic [LEN_WIDTH-1:0]         cmd_len,
  output logic                         lut_start,
  output logic [ADDR_WIDTH-1:0]        lut_addr,
  input  logic [DATA_WIDTH-1:0]        lut_data,
  input  logic                         lut_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PACK*DATA_WIDTH-1:0]   out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         err
);

  localparam int WORD_W = PACK * DATA_WIDTH;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            table_q, table_d;
  logic [15:0]            base_q,  base_d;
  logic [LEN_WIDTH-1:0]   len_q,   len_d;
  logic [LEN_WIDTH-1:0]   idx_q,   idx_d;
  logic [LANE_W-1:0]      lane_q,  lane_d;
  logic [WORD_W-1:0]      pack_q,  pack_d;

  // FIFO storage: {last, word}
  logic [WORD_W:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wptr_q, rptr_q;
  logic [CNT_W-1:0]       count_q;

  logic                   w_push;
  logic                   w_pop;
  logic [WORD_W-1:0]      w_push_word;
  logic                   w_push_last;
  logic [WORD_W-1:0]      w_merged;
  logic                   w_is_last;
  logic                   w_lane_full;
  logic                   w_fifo_space;
  logic [15:0]            w_off;
  logic [WORD_W:0]        w_head;

`ifdef WFS_TIMEOUT_EN
  logic                   err_q, err_d;
  logic [7:0]             wdog_q, wdog_d;
`endif

  // Offset arithmetic is 16-bit and wraps; the table field never carries.
  assign w_off        = base_q + 16'(idx_q);
  assign lut_addr     = ADDR_WIDTH'({table_q, w_off});
  assign w_is_last    = (idx_q == (len_q - LEN_WIDTH'(1)));
  assign w_lane_full  = (lane_q == LANE_W'(PACK - 1));
  assign w_fifo_space = (count_q < CNT_W'(FIFO_DEPTH));

  // Pack register with the current lane overwritten by the returning byte.
  always_comb begin
    w_merged = pack_q;
    for (int k = 0; k < PACK; k++) begin
      if (lane_q == LANE_W'(k)) begin
        w_merged[k*DATA_WIDTH +: DATA_WIDTH] = lut_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    table_d     = table_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    cmd_ready   = 1'b0;
    lut_start   = 1'b0;
    w_push      = 1'b0;
    w_push_word = w_merged;
    w_push_last = 1'b0;
`ifdef WFS_TIMEOUT_EN
    err_d       = err_q;
    wdog_d      = 8'd0;
`endif

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
`ifdef WFS_TIMEOUT_EN
          err_d = 1'b0;
`endif
          // A zero-length command is consumed without any reads.
          if (cmd_len != '0) begin
            table_d = cmd_table;
            base_d  = cmd_base;
            len_d   = cmd_len;
            idx_d   = '0;
            lane_d  = '0;
            pack_d  = '0;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        // Only launch a read when the word it might complete has a FIFO slot.
        if (w_fifo_space) begin
          lut_start = 1'b1;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        if (lut_done) begin
          if (w_is_last || w_lane_full) begin
            w_push      = 1'b1;
            w_push_word = w_merged;
            w_push_last = w_is_last;
            pack_d      = '0;
            lane_d      = '0;
          end else begin
            pack_d = w_merged;
            lane_d = lane_q + LANE_W'(1);
          end
          idx_d   = idx_q + LEN_WIDTH'(1);
          state_d = w_is_last ? S_IDLE : S_ISSUE;
`ifdef WFS_TIMEOUT_EN
        end else if (wdog_q == 8'd254) begin
          // 255th WAIT cycle with no response: abort and flush any partial word.
          err_d = 1'b1;
          if (lane_q != '0) begin
            w_push      = 1'b1;
            w_push_word = pack_q;
            w_push_last = 1'b1;
          end
          pack_d  = '0;
          lane_d  = '0;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      table_q <= '0;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      pack_q  <= '0;
`ifdef WFS_TIMEOUT_EN
      err_q   <= 1'b0;
      wdog_q  <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      table_q <= table_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
`ifdef WFS_TIMEOUT_EN
      err_q   <= err_d;
      wdog_q  <= wdog_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Output word FIFO
  // --------------------------------------------------------------------------
  assign out_valid = (count_q != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_head    = mem_q[rptr_q];
  // Head is masked while empty so stale entries never appear on the port.
  assign out_data  = out_valid ? w_head[WORD_W-1:0] : '0;
  assign out_last  = out_valid ? w_head[WORD_W]     : 1'b0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wptr_q] <= {w_push_last, w_push_word};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + PTR_W'(1);
      if (w_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE) || out_valid;

`ifdef WFS_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire
